// File: rtl/ddr3_sched_pkg.sv
// Shared constants for the ddr3_app_if round-robin scheduler: FSM state
// encodings, transfer direction codes and the dword address width helper.
package ddr3_sched_pkg;

  localparam logic [2:0] ST_ARB   = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  // Byte address -> dword address width
  function automatic int dword_aw(input int mem_addr_depth);
    return mem_addr_depth - 2;
  endfunction

endpackage

// File: rtl/ddr3_rr_arb.sv
// Combinational rotate-priority encoder: picks the first requester at or
// after ptr_i (wrapping) and returns it one-hot plus as an index.
module ddr3_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan from the pointer upwards, first hit wins
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/ddr3_app_sched.sv
// Round-robin scheduler sharing one ddr3_app_if between NUM_REQ requesters.
// Optional DDR3_APP_SCHED_STATS_EN adds transfer/dword statistics outputs.
module ddr3_app_sched
  import ddr3_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int CNT_W          = 24,
  localparam int AW            = dword_aw(MEM_ADDR_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_init_calib_complete,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_req_wr,
  input  logic [NUM_REQ*AW-1:0]    i_req_addr,
  input  logic [NUM_REQ*CNT_W-1:0] i_req_count,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic                     o_ingress_en,
  output logic [AW-1:0]            o_ingress_dword_addr,
  output logic                     o_egress_en,
  output logic [AW-1:0]            o_egress_dword_addr,
  input  logic                     i_app_if_idle,
  input  logic                     i_ingress_stb,
  input  logic                     i_egress_stb
`ifdef DDR3_APP_SCHED_STATS_EN
  ,
  output logic [31:0]              o_stat_xfers,
  output logic [31:0]              o_stat_dwords
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               busy_q, busy_d, wr_q, wr_d;
  logic               ing_en_q, ing_en_d, egr_en_q, egr_en_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d, cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_valid_s, run_stb_s;
  logic [CNT_W-1:0]   req_count_s;

  ddr3_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  assign req_count_s = i_req_count[arb_idx_s*CNT_W +: CNT_W];
  assign run_stb_s   = (wr_q == DIR_WR) ? i_ingress_stb : i_egress_stb;

  // Transfer FSM: arbitrate, enable the engine, count strobes, drain, ack
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    ing_en_d = ing_en_q;
    egr_en_d = egr_en_q;
    case (state_q)
      ST_ARB: begin
        if (i_init_calib_complete && arb_valid_s && i_app_if_idle) begin
          idx_d   = arb_idx_s;
          grant_d = arb_grant_s;
          busy_d  = 1'b1;
          wr_d    = i_req_wr[arb_idx_s];
          addr_d  = i_req_addr[arb_idx_s*AW +: AW];
          count_d = req_count_s;
          state_d = (req_count_s == '0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_ISSUE: begin
        ing_en_d = (wr_q == DIR_WR);
        egr_en_d = (wr_q == DIR_RD);
        if (!i_app_if_idle) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RUN: begin
        // Equality compare: the engine is released on the exact final dword
        if (run_stb_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == count_q) begin
            ing_en_d = 1'b0;
            egr_en_d = 1'b0;
            state_d  = ST_DRAIN;
          end else begin
            ing_en_d = (wr_q == DIR_WR);
            egr_en_d = (wr_q == DIR_RD);
          end
        end else begin
          ing_en_d = (wr_q == DIR_WR);
          egr_en_d = (wr_q == DIR_RD);
        end
      end
      ST_DRAIN: begin
        ing_en_d = 1'b0;
        egr_en_d = 1'b0;
        if (i_app_if_idle) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        done_d  = grant_q;
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = ST_ARB;
      end
      default: begin
        grant_d  = '0;
        busy_d   = 1'b0;
        cnt_d    = '0;
        ing_en_d = 1'b0;
        egr_en_d = 1'b0;
        state_d  = ST_ARB;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ARB;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      ing_en_q <= 1'b0;
      egr_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      ing_en_q <= ing_en_d;
      egr_en_q <= egr_en_d;
    end
  end

  assign o_grant              = grant_q;
  assign o_done               = done_q;
  assign o_busy               = busy_q;
  assign o_ingress_en         = ing_en_q;
  assign o_egress_en          = egr_en_q;
  assign o_ingress_dword_addr = addr_q;
  assign o_egress_dword_addr  = addr_q;

`ifdef DDR3_APP_SCHED_STATS_EN
  logic [31:0] stat_xfers_q, stat_dwords_q;

  // Wrapping counters of completed transfers and counted dwords
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_xfers_q  <= 32'd0;
      stat_dwords_q <= 32'd0;
    end else begin
      stat_xfers_q  <= stat_xfers_q + ((state_q == ST_DONE) ? 32'd1 : 32'd0);
      stat_dwords_q <= stat_dwords_q + (((state_q == ST_RUN) && run_stb_s) ? 32'd1 : 32'd0);
    end
  end

  assign o_stat_xfers  = stat_xfers_q;
  assign o_stat_dwords = stat_dwords_q;
`endif

endmodule
